// File: rtl/sparse_pe_lanes.sv
// Sparse-CNN processing element: streams one channel's feature x weight cartesian product,
// LANES products per beat, through an operand-select stage and a multiply/mask output stage.
module sparse_pe_lanes #(
  parameter int COL_LENGTH  = 8,
  parameter int WORD_LENGTH = 8,
  parameter int LANES       = 4,
  parameter int MAX_FEAT    = 52,
  parameter int MAX_WEIGHT  = 28,
  parameter int KERNEL_SIZE = 5,
  parameter int IMAGE_SIZE  = 7,
  parameter int CH_BITS     = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [CH_BITS-1:0]                 in_channel,
  input  logic [15:0]                        feature_valid_num,
  input  logic [MAX_FEAT*WORD_LENGTH-1:0]    feature_value,
  input  logic [MAX_FEAT*COL_LENGTH-1:0]     feature_cols,
  input  logic [MAX_FEAT*COL_LENGTH-1:0]     feature_rows,
  input  logic [15:0]                        weight_valid_num,
  input  logic [MAX_WEIGHT*WORD_LENGTH-1:0]  weight_value,
  input  logic [MAX_WEIGHT*COL_LENGTH-1:0]   weight_cols,
  input  logic [MAX_WEIGHT*COL_LENGTH-1:0]   weight_rows,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [LANES*2*WORD_LENGTH-1:0]     data_out,
  output logic [LANES*COL_LENGTH-1:0]        data_out_cols,
  output logic [LANES*COL_LENGTH-1:0]        data_out_rows,
  output logic [LANES-1:0]                   lane_mask,
  output logic [CH_BITS-1:0]                 out_channel,
  output logic                               done
);
  localparam int FW    = $clog2(MAX_FEAT + 1);
  localparam int FI    = $clog2(MAX_FEAT);
  localparam int WW    = $clog2(MAX_WEIGHT + 1);
  localparam int WI    = $clog2(MAX_WEIGHT);
  localparam int CW    = COL_LENGTH + 1;
  localparam int PW    = 2 * WORD_LENGTH;
  localparam int RANGE = IMAGE_SIZE - KERNEL_SIZE;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  state_t               r_state;
  logic                 r_in_ready, r_done, r_s1_valid, r_out_valid;
  logic [FW-1:0]        r_fnum, r_fbase;
  logic [WW-1:0]        r_wnum, r_w;
  logic [CH_BITS-1:0]   r_chan, r_out_channel;

  logic signed [WORD_LENGTH-1:0] r_fv [MAX_FEAT];
  logic [COL_LENGTH-1:0]         r_fc [MAX_FEAT];
  logic [COL_LENGTH-1:0]         r_fr [MAX_FEAT];
  logic signed [WORD_LENGTH-1:0] r_wv [MAX_WEIGHT];
  logic [COL_LENGTH-1:0]         r_wc [MAX_WEIGHT];
  logic [COL_LENGTH-1:0]         r_wr [MAX_WEIGHT];

  logic signed [WORD_LENGTH-1:0] r_s1_fv [LANES];
  logic [COL_LENGTH-1:0]         r_s1_fc [LANES];
  logic [COL_LENGTH-1:0]         r_s1_fr [LANES];
  logic [LANES-1:0]              r_s1_ok;
  logic signed [WORD_LENGTH-1:0] r_s1_wv;
  logic [COL_LENGTH-1:0]         r_s1_wc, r_s1_wr;

  logic [LANES*PW-1:0]         r_data, w_data;
  logic [LANES*COL_LENGTH-1:0] r_cols, r_rows, w_cols, w_rows;
  logic [LANES-1:0]            r_mask, w_mask;
  logic [LANES*FI-1:0]         w_faddr;

  logic          w_adv, w_issue, w_last_w, w_last_f;
  logic [FW-1:0] w_fnum;
  logic [WW-1:0] w_wnum;
  logic [FW:0]   w_fnext;

  assign w_fnum   = (feature_valid_num > 16'(MAX_FEAT))  ? FW'(MAX_FEAT)   : feature_valid_num[FW-1:0];
  assign w_wnum   = (weight_valid_num  > 16'(MAX_WEIGHT)) ? WW'(MAX_WEIGHT) : weight_valid_num[WW-1:0];
  // Both pipeline stages move together, so a stalled output also freezes the step counters.
  assign w_adv    = !r_out_valid || out_ready;
  assign w_issue  = (r_state == RUN) && w_adv;
  assign w_fnext  = {1'b0, r_fbase} + (FW+1)'(LANES);
  assign w_last_f = w_fnext >= {1'b0, r_fnum};
  assign w_last_w = r_w == (r_wnum - WW'(1));

  always_ff @(posedge clk) begin
    if ((r_state == IDLE) && in_valid) begin
      for (int i = 0; i < MAX_FEAT; i++) begin
        r_fv[i] <= feature_value[i*WORD_LENGTH +: WORD_LENGTH];
        r_fc[i] <= feature_cols[i*COL_LENGTH +: COL_LENGTH];
        r_fr[i] <= feature_rows[i*COL_LENGTH +: COL_LENGTH];
      end
      for (int i = 0; i < MAX_WEIGHT; i++) begin
        r_wv[i] <= weight_value[i*WORD_LENGTH +: WORD_LENGTH];
        r_wc[i] <= weight_cols[i*COL_LENGTH +: COL_LENGTH];
        r_wr[i] <= weight_rows[i*COL_LENGTH +: COL_LENGTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_issue) begin
      for (int i = 0; i < LANES; i++) begin
        r_s1_fv[i] <= r_fv[w_faddr[i*FI +: FI]];
        r_s1_fc[i] <= r_fc[w_faddr[i*FI +: FI]];
        r_s1_fr[i] <= r_fr[w_faddr[i*FI +: FI]];
        r_s1_ok[i] <= ({1'b0, r_fbase} + (FW+1)'(i)) < {1'b0, r_fnum};
      end
      r_s1_wv <= r_wv[WI'(r_w)];
      r_s1_wc <= r_wc[WI'(r_w)];
      r_s1_wr <= r_wr[WI'(r_w)];
    end
  end

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      logic [FW:0]            w_f;
      logic signed [CW-1:0]   w_dc, w_dr;
      logic signed [PW-1:0]   w_prod;
      logic                   w_hit;
      // Lanes past the end of the list read entry 0; they are masked off anyway.
      assign w_f = {1'b0, r_fbase} + (FW+1)'(gi);
      assign w_faddr[gi*FI +: FI] = (w_f < (FW+1)'(MAX_FEAT)) ? FI'(w_f) : '0;
      assign w_dc   = $signed({1'b0, r_s1_fc[gi]}) - $signed({1'b0, r_s1_wc});
      assign w_dr   = $signed({1'b0, r_s1_fr[gi]}) - $signed({1'b0, r_s1_wr});
      assign w_prod = PW'(r_s1_fv[gi]) * PW'(r_s1_wv);
      assign w_hit  = r_s1_valid && r_s1_ok[gi] && !w_dc[CW-1] && !w_dr[CW-1]
                      && (w_dc <= CW'(RANGE)) && (w_dr <= CW'(RANGE));
      assign w_mask[gi] = w_hit;
      assign w_data[gi*PW +: PW] = w_hit ? w_prod : '0;
      assign w_cols[gi*COL_LENGTH +: COL_LENGTH] = w_hit ? w_dc[COL_LENGTH-1:0] : '0;
      assign w_rows[gi*COL_LENGTH +: COL_LENGTH] = w_hit ? w_dr[COL_LENGTH-1:0] : '0;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= IDLE;
      r_in_ready    <= 1'b1;
      r_done        <= 1'b0;
      r_fnum        <= '0;
      r_wnum        <= '0;
      r_chan        <= '0;
      r_fbase       <= '0;
      r_w           <= '0;
      r_s1_valid    <= 1'b0;
      r_out_valid   <= 1'b0;
      r_data        <= '0;
      r_cols        <= '0;
      r_rows        <= '0;
      r_mask        <= '0;
      r_out_channel <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: if (in_valid) begin
          r_fnum     <= w_fnum;
          r_wnum     <= w_wnum;
          r_chan     <= in_channel;
          r_fbase    <= '0;
          r_w        <= '0;
          r_in_ready <= 1'b0;
          r_state    <= ((w_fnum == '0) || (w_wnum == '0)) ? FLUSH : RUN;
        end
        RUN: if (w_adv) begin
          if (w_last_w) begin
            r_w <= '0;
            if (w_last_f) r_state <= FLUSH;
            else          r_fbase <= w_fnext[FW-1:0];
          end else begin
            r_w <= r_w + WW'(1);
          end
        end
        FLUSH: begin
          if (r_done) begin
            r_state    <= IDLE;
            r_in_ready <= 1'b1;
          end else if (!r_s1_valid && w_adv) begin
            r_done <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
      if (w_adv) begin
        r_s1_valid    <= w_issue;
        r_out_valid   <= r_s1_valid;
        r_data        <= w_data;
        r_cols        <= w_cols;
        r_rows        <= w_rows;
        r_mask        <= w_mask;
        r_out_channel <= r_s1_valid ? r_chan : '0;
      end
    end
  end

  assign in_ready      = r_in_ready;
  assign out_valid     = r_out_valid;
  assign data_out      = r_data;
  assign data_out_cols = r_cols;
  assign data_out_rows = r_rows;
  assign lane_mask     = r_mask;
  assign out_channel   = r_out_channel;
  assign done          = r_done;
endmodule
